// File: rtl/div_iter_m.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish one cycle after accept.
//
// state  | meaning
// S_IDLE | waiting for a request, in_ready=1
// S_CALC | shifting/subtracting, one quotient bit per edge
// S_DONE | result registered, out_valid=1 until out_ready
module div_iter_m #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvsr;
  logic            remsel;
  logic            neg_q;
  logic            neg_r;

  logic            accept;
  logic            is_signed;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_sub;
  logic            rem_ge;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] res_fix;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready && !flush;

  assign is_signed = ~op[0];
  assign sign_a    = is_signed & opA[XLEN-1];
  assign sign_b    = is_signed & opB[XLEN-1];
  assign abs_a     = sign_a ? -opA : opA;
  assign abs_b     = sign_b ? -opB : opB;

  // Partial remainder stays below the divisor, so the difference always fits in XLEN bits.
  assign rem_sh  = {rem, quo[XLEN-1]};
  assign rem_ge  = (rem_sh >= {1'b0, dvsr});
  assign rem_sub = rem_sh[XLEN-1:0] - dvsr;
  assign rem_nxt = rem_ge ? rem_sub : rem_sh[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], rem_ge};

  assign res_fix = remsel ? (neg_r ? -rem_nxt : rem_nxt)
                          : (neg_q ? -quo_nxt : quo_nxt);

`ifdef DIV_FAST_SPECIAL_EN
  logic            b_zero;
  logic            ovf;
  logic [XLEN-1:0] special_res;

  assign b_zero      = (opB == '0);
  assign ovf         = is_signed && (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1);
  assign special_res = op[1] ? (b_zero ? opA : '0) : (b_zero ? '1 : opA);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      count  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      remsel <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            remsel <= op[1];
            // A zero divisor keeps the all-ones quotient; the remainder still gets
            // its sign back so it equals the original dividend.
            neg_q  <= (sign_a ^ sign_b) && (opB != '0);
            neg_r  <= sign_a;
            quo    <= abs_a;
            dvsr   <= abs_b;
            rem    <= '0;
            count  <= CW'(XLEN-1);
`ifdef DIV_FAST_SPECIAL_EN
            if (b_zero || ovf) begin
              result <= special_res;
              state  <= S_DONE;
            end else begin
              state  <= S_CALC;
            end
`else
            state  <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          rem   <= rem_nxt;
          quo   <= quo_nxt;
          count <= count - CW'(1);
          if (count == '0) begin
            result <= res_fix;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
